// File: rtl/freq_scan_uart_if.sv
// Bus for freq_scan_uart: measured inputs, scan control, UART line and status.
// The master side (environment) drives sig_in/ch_mask/enable; the slave side
// (the meter) drives the UART line, status flags and FSM state for observation.
interface freq_scan_uart_if #(
    parameter int N_CH = 16
);
    logic [N_CH-1:0] sig_in;
    logic [N_CH-1:0] ch_mask;
    logic            enable;
    logic            uart_out;
    logic            busy;
    logic            frame_done;
    logic [7:0]      cur_ch;
    logic [2:0]      fsm_state;

    modport master (
        output sig_in, ch_mask, enable,
        input  uart_out, busy, frame_done, cur_ch, fsm_state
    );

    modport slave (
        input  sig_in, ch_mask, enable,
        output uart_out, busy, frame_done, cur_ch, fsm_state
    );
endinterface

// File: rtl/freq_scan_uart.sv
// freq_scan_uart: round-robin multi-channel frequency meter with UART reports.
// Each enabled channel is gated for GATE_CYC cycles, its rising edges counted
// (saturating), then a frame A5, ch, count (MSB first), XOR checksum is sent.
// Optional macro PARITY_EN: adds an even-parity bit per character (8E1);
// without it characters are 8N1.
module freq_scan_uart #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 9600,
    parameter int N_CH      = 16,
    parameter int GATE_CYC  = 12500000,
    parameter int CNT_BYTES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    freq_scan_uart_if.slave  bus
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CNT_W   = 8 * CNT_BYTES;
    localparam int N_BYTES = 3 + CNT_BYTES;
`ifdef PARITY_EN
    localparam int CHAR_BITS = 11;
`else
    localparam int CHAR_BITS = 10;
`endif
    localparam int GW  = $clog2(GATE_CYC + 1);
    localparam int BW  = $clog2(BIT_CYC + 1);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        GATE   = 3'd2,
        LATCH  = 3'd3,
        SEND   = 3'd4,
        NEXT   = 3'd5
    } state_t;

    state_t state, state_next;

    logic [N_CH-1:0]  sync1, sync2, edge_q, rise;
    logic             rise_sel;
    logic [CNT_W-1:0] edge_cnt;
    logic [GW-1:0]    gate_cnt;
    logic [BW-1:0]    baud_cnt;
    logic [3:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic [7:0]       frame [N_BYTES];
    logic [7:0]       cur_ch, sel_ch, csum;
    logic             sel_found;
    logic             uart_q, busy_q, frame_done_q;
    logic             gate_last, baud_last, char_last, byte_last, send_last;
    logic             run_ok, next_bit;
    int               idx;

    // Character bit i of data byte d: start, 8 data LSB first, [parity], stop.
    function automatic logic tx_bit(input logic [7:0] d, input logic [3:0] i);
        logic b;
        b = 1'b1;
        if (i == 4'd0)
            b = 1'b0;
        else if (i <= 4'd8)
            b = d[3'(i - 4'd1)];
`ifdef PARITY_EN
        else if (i == 4'd9)
            b = ^d;
`endif
        return b;
    endfunction

    // Two-flop synchroniser plus edge register over all channels; runs freely
    // so channel switches do not need to re-prime it.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= bus.sig_in;
            sync2  <= sync1;
            edge_q <= sync2;
        end
    end

    assign rise     = sync2 & ~edge_q;
    assign rise_sel = rise[cur_ch[CHW-1:0]];

    // Find the first enabled channel at or above cur_ch, wrapping around.
    // Iterating from the farthest offset down lets the nearest one win.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = cur_ch;
        idx       = 0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = int'(cur_ch) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (bus.ch_mask[idx]) begin
                sel_found = 1'b1;
                sel_ch    = 8'(idx);
            end
        end
    end

    // Checksum over sync byte, channel and count bytes.
    always_comb begin
        csum = SYNC_BYTE ^ cur_ch;
        for (int b = 0; b < CNT_BYTES; b++)
            csum = csum ^ edge_cnt[8*b +: 8];
    end

    assign gate_last = (gate_cnt == GW'(GATE_CYC - 1));
    assign baud_last = (baud_cnt == BW'(BIT_CYC - 1));
    assign char_last = (bit_idx == 4'(CHAR_BITS - 1));
    assign byte_last = (byte_idx == 3'(N_BYTES - 1));
    assign send_last = baud_last && char_last && byte_last;
    assign run_ok    = bus.enable && (|bus.ch_mask);
    assign next_bit  = tx_bit(frame[byte_idx], bit_idx + 4'd1);

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run_ok) state_next = SELECT;
            SELECT:  state_next = sel_found ? GATE : IDLE;
            GATE:    if (gate_last) state_next = LATCH;
            LATCH:   state_next = SEND;
            SEND:    if (send_last) state_next = NEXT;
            NEXT:    state_next = run_ok ? SELECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: channel select, gate counting, frame build and UART shifting.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cur_ch       <= '0;
            edge_cnt     <= '0;
            gate_cnt     <= '0;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            uart_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int b = 0; b < N_BYTES; b++) frame[b] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                IDLE: busy_q <= 1'b0;
                SELECT: begin
                    if (sel_found) begin
                        cur_ch   <= sel_ch;
                        edge_cnt <= '0;
                        gate_cnt <= '0;
                        busy_q   <= 1'b1;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    if (rise_sel && (edge_cnt != {CNT_W{1'b1}}))
                        edge_cnt <= edge_cnt + 1'b1;
                end
                LATCH: begin
                    frame[0] <= SYNC_BYTE;
                    frame[1] <= cur_ch;
                    for (int b = 0; b < CNT_BYTES; b++)
                        frame[2+b] <= edge_cnt[8*(CNT_BYTES-1-b) +: 8];
                    frame[N_BYTES-1] <= csum;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                    baud_cnt <= '0;
                    uart_q   <= 1'b0;
                end
                SEND: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (char_last) begin
                            if (byte_last) begin
                                uart_q       <= 1'b1;
                                frame_done_q <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                bit_idx  <= '0;
                                uart_q   <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            uart_q  <= next_bit;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    cur_ch <= (cur_ch == 8'(N_CH - 1)) ? 8'd0 : cur_ch + 8'd1;
                    if (!run_ok) busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.uart_out   = uart_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.cur_ch     = cur_ch;
    assign bus.fsm_state  = state;
endmodule

// File: doc/freq_scan_uart.md
Name: freq_scan_uart

Overview:
Parametrised multi-channel frequency meter with built-in UART reporting. It scans the enabled channels of sig_in in round-robin order. For each channel it counts rising edges over a fixed gate window, then transmits a framed, checksummed result over an 8N1 UART. It generalises the existing 16-input, 0.25 s, 8-bit, 9600-baud counter path with the following changes:
- configurable channel count, gate time, count width and baud rate;
- per-channel masking;
- a single clock domain using clock enables instead of derived clocks.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 9600, UART bit rate; bit period BIT_CYC = CLK_HZ/BAUD cycles (integer division)
N_CH, 16, number of input channels (2..256)
GATE_CYC, 12500000, gate window length in clk_in cycles (default = 0.25 s)
CNT_BYTES, 2, count width in bytes; CNT_W = 8*CNT_BYTES (1..4)

Ports:
clk_in  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
sig_in  input  N_CH  asynchronous signals to measure
ch_mask  input  N_CH  1 = channel included in scan; sampled at each channel selection
enable  input  1  1 = scanning runs; 0 = stop after current frame completes
uart_out  output  1  UART TX line, idles high
busy  output  1  high from gate start until stop bit of last frame byte ends
frame_done  output  1  one-cycle pulse when the last stop bit of a frame completes
cur_ch  output  8  index of channel currently gated or being reported

Behaviour:
- Reset (reset==0 at clk_in edge): uart_out=1, busy=0, frame_done=0, cur_ch=0, state=IDLE, all counters cleared. This applies mid-gate or mid-frame; uart_out returns high on the same edge.
- Input path: sig_in passes a 2-FF synchroniser plus an edge register. A rising edge at the pin is counted 3 cycles later. Edges landing in the synchroniser at gate close are dropped. The synchroniser is not cleared between channels.
- FSM states: IDLE, SELECT, GATE, LATCH, SEND, NEXT.
- IDLE: leave when enable==1 and ch_mask!=0 -> SELECT. If mask is all zero, stay in IDLE with busy=0.
- SELECT (1 cycle): search upward from cur_ch, wrapping at N_CH-1 to 0, for the first set mask bit, cur_ch included. Load cur_ch, clear edge counter and gate counter -> GATE; busy=1.
- GATE: exactly GATE_CYC cycles; the edge counter increments on each synchronised rising edge of sig_in[cur_ch].
  - Edge counter saturates at 2^CNT_W-1 and does not wrap.
- LATCH (1 cycle): copy count to shift buffer; build frame bytes; -> SEND.
- Frame format, bytes sent in order:
  - 0xA5 sync;
  - cur_ch;
  - count MSB first (CNT_BYTES bytes);
  - checksum = XOR of all preceding frame bytes.
  - Total 3+CNT_BYTES bytes.
- SEND: each byte is start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BIT_CYC cycles.
  - The baud counter restarts at the first start bit; bytes are back-to-back with no idle gap.
  - frame_done pulses on the cycle after the final stop bit ends -> NEXT.
- NEXT: advance cur_ch by 1 (mod N_CH).
  - If enable==1 and ch_mask!=0 -> SELECT; otherwise -> IDLE, busy=0.
  - There is no counting while SEND is active: gate windows do not overlap transmission.
- Changing ch_mask mid-gate does not abort the current channel. Changing enable to 0 mid-gate completes gate and frame.
- N_CH==1: cur_ch stays 0; frames repeat continuously.

Optional Feature:
PARITY_EN: when defined, each UART byte carries an even-parity bit (XOR of the 8 data bits) between data bit 7 and the stop bit. Characters are 11 bits, 8E1. When undefined, framing is 8N1 (10 bits per character) and no parity logic is present.

Test Plan:
- Sim params: CLK_HZ=1000, BAUD=100 (BIT_CYC=10), N_CH=4, GATE_CYC=100, CNT_BYTES=2.
- Reset: hold reset=0 for 5 cycles with enable=1 -> uart_out=1, busy=0, cur_ch=0, no frame_done.
- Basic count: ch_mask=4'b1000, enable=1, sig_in[3] period-10 square wave -> frame bytes A5 03 00 0A AC, 50 bits of 10 cycles each, then frame_done single pulse.
- Round-robin and mask: ch_mask=4'b0101, sig_in[0] period 20, sig_in[2] constant 0 -> frames for ch0 (count 0x0005, checksum A0), then ch2 (count 0x0000, checksum A7), then ch0 again; ch1/ch3 never reported.
- Saturation: CNT_BYTES=1, GATE_CYC=1000, sig_in[0] period 2 (500 edges), mask 4'b0001 -> count byte 0xFF, checksum A5^00^FF=5A.
- Reset mid-frame and stop: assert reset=0 during the third data bit of byte 1 -> uart_out=1 on that edge, IDLE afterwards. Separately, drop enable during GATE -> that frame completes, then busy=0 and the line stays idle high.
- PARITY_EN defined: repeat the basic count test -> 55 bits per frame; parity bits 0,0,0,0,0 for bytes A5,03,00,0A,AC.
